bios_port_arbiter: RTL and testbench
====================================

Name: bios_port_arbiter

Overview:
- Shares one synchronous-read port of the BIOS memory (1-cycle read latency, 12-bit byte address, 32-bit word data) between two independent read requesters.
- Requester 0 is instruction fetch; requester 1 is data load / debug.
- Sits between the CPU front-end/LSU and one BIOS memory port.
- Provides per-requester req/gnt issue, buffered valid/ready responses, alignment checking and round-robin or fixed-priority arbitration.

Parameters:
- ADDR_W, 12, byte address width presented to the memory port.
- DATA_W, 32, read data width.
- PRIO_MODE, 0, arbitration mode: 0 = round-robin; 1 = fixed priority with requester 0 winning.
- CHECK_ALIGN, 1, when 1, a request with addr[1:0] != 0 returns an error response and does not access memory.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- m0_req  in  1  requester 0 read request.
- m0_addr  in  ADDR_W  requester 0 byte address.
- m0_gnt  out  1  requester 0 request accepted this cycle (combinational).
- m0_rsp_valid  out  1  requester 0 response buffered.
- m0_rsp_ready  in  1  requester 0 accepts its response.
- m0_rsp_data  out  DATA_W  requester 0 response data.
- m0_rsp_err  out  1  requester 0 misaligned-access flag.
- m1_req, m1_addr, m1_gnt, m1_rsp_valid, m1_rsp_ready, m1_rsp_data, m1_rsp_err  identical set for requester 1.
- mem_en  out  1  memory port enable.
- mem_addr  out  ADDR_W  memory port byte address.
- mem_dout  in  DATA_W  memory read data, valid the cycle after mem_en.

Behaviour:
- Reset (async, rst_n=0) clears all of the following immediately:
  - in-flight valid, owner, error flag;
  - both response buffers (rsp_valid=0, rsp_data=0, rsp_err=0);
  - round-robin pointer (next preference = requester 0).
- While in reset, gnt, mem_en and mem_addr are 0. A request outstanding when reset asserts is dropped with no response.
- Eligibility: eligible_i = mi_req & !inflight_i & (!mi_rsp_valid | mi_rsp_ready).
  - At most one outstanding transaction per requester, counting in-flight and buffered.
  - A buffer being popped in the same cycle frees its requester.
- Arbitration (combinational each cycle):
  - One eligible requester: it wins.
  - Both eligible, PRIO_MODE=0: the pointer holder wins. The pointer moves to the other requester after every grant.
  - Both eligible, PRIO_MODE=1: requester 0 always wins. The pointer is unused.
  - At most one gnt per cycle. gnt is never asserted without req.
- Issue cycle T, winner i:
  - gnt_i=1; mem_addr = addr_i.
  - mem_en=1 unless (CHECK_ALIGN & addr_i[1:0]!=0).
  - Registered at the edge: inflight valid, owner=i, err=misaligned.
  - No grant: mem_en=0, mem_addr holds its previous value.
- Cycle T+1, capture:
  - buffer_owner.data <= err ? 0 : mem_dout.
  - buffer_owner.err <= err.
  - buffer_owner.valid <= 1.
  - inflight cleared.
- Latency: rsp_valid rises at T+2 (two cycles from gnt).
  - Back-to-back alternating requests sustain one grant per cycle on the port.
  - A single requester sustains one grant per two cycles.
- Response handshake:
  - A buffer holds data, err and valid until rsp_valid & rsp_ready; it then clears on that edge.
  - rsp_data is stable while valid.
  - rsp_ready with no valid is ignored.
- Simultaneous pop and capture on the same buffer cannot occur, because eligibility forbids it.
- Address wrap: none. Addresses are passed through unmodified; the memory port ignores addr[1:0].

Decomposition:
- Shared package bios_arb_pkg holds:
  - ADDR_W, DATA_W defaults;
  - requester-id type (1 bit: REQ_FETCH=0, REQ_DATA=1);
  - PRIO_RR / PRIO_FIXED constants.
- One sub-module, rr_arb2: 2-way round-robin/fixed picker with registered pointer. Inputs are eligible[1:0] and mode; outputs are a one-hot grant and a pointer update. The rest (in-flight stage, two response buffers) stays in bios_port_arbiter.

Test Plan:
- Reset release, m0 reads 0x010 with mem word 4 = 0xDEADBEEF, rsp_ready=1 -> m0_gnt at T, mem_en=1, mem_addr=0x010 at T; m0_rsp_valid=1, data=0xDEADBEEF, err=0 at T+2.
- Both requesting every cycle, PRIO_MODE=0, addresses 0x000 and 0x004 -> grants alternate m0,m1,m0,m1; mem_en high every cycle; each requester receives correct data two cycles after each grant.
- PRIO_MODE=1, both requesting continuously -> m0 granted at T, T+2, T+4; m1 granted only at T+1, T+3 (m0 ineligible while in flight).
- m1 reads 0x006, CHECK_ALIGN=1 -> m1_gnt=1, mem_en=0; m1_rsp_valid at T+2 with err=1, data=0.
- m0 holds rsp_ready=0 for 5 cycles -> rsp_data stable and no further m0_gnt; m0_rsp_ready=1 on cycle 6 allows a new m0_gnt that same cycle.
- rst_n pulsed low at T+1 with a request in flight -> all outputs 0 immediately and no response after release; next request served normally with m0 preferred.

Source files
------------

// File: rtl/bios_arb_pkg.sv
// Shared types and defaults for the BIOS memory port arbiter.
package bios_arb_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;

  localparam bit PRIO_RR    = 1'b0;
  localparam bit PRIO_FIXED = 1'b1;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_DATA  = 1'b1
  } req_id_e;

  // One read travelling from issue to capture.
  typedef struct packed {
    logic    vld;
    req_id_e own;
    logic    err;
  } infl_t;

endpackage

// File: rtl/bios_port_arbiter_rr_arb2.sv
// 2-way picker: round-robin with a registered preference pointer, or fixed
// priority to requester 0.
module rr_arb2
  import bios_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] elig_i,
  input  logic       mode_i,
  output logic [1:0] gnt_o
);

  req_id_e ptr_q, ptr_d;

  always_comb begin
    gnt_o = elig_i;
    if (&elig_i)
      gnt_o = (mode_i == PRIO_FIXED || ptr_q == REQ_FETCH) ? 2'b01 : 2'b10;
    // Preference always moves to whoever was not just served.
    ptr_d = ptr_q;
    if (gnt_o[0])      ptr_d = REQ_DATA;
    else if (gnt_o[1]) ptr_d = REQ_FETCH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= REQ_FETCH;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/bios_port_arbiter.sv
// Shares one 1-cycle-latency BIOS read port between instruction fetch (0) and
// data/debug (1), with one buffered response per requester.
module bios_port_arbiter
  import bios_arb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter bit PRIO_MODE   = PRIO_RR,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  output logic              m0_gnt,
  output logic              m0_rsp_valid,
  input  logic              m0_rsp_ready,
  output logic [DATA_W-1:0] m0_rsp_data,
  output logic              m0_rsp_err,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  output logic              m1_gnt,
  output logic              m1_rsp_valid,
  input  logic              m1_rsp_ready,
  output logic [DATA_W-1:0] m1_rsp_data,
  output logic              m1_rsp_err,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout
);

  logic [1:0]             req, rdy, inflight, elig, gnt_raw, gnt;
  logic [1:0][ADDR_W-1:0] addr;
  logic                   win, misal;
  logic [ADDR_W-1:0]      win_addr, addr_q;
  infl_t                  infl_q, infl_d;

  logic [1:0]             rsp_vld_q, rsp_vld_d, rsp_err_q, rsp_err_d;
  logic [1:0][DATA_W-1:0] rsp_data_q, rsp_data_d;

  assign req  = {m1_req, m0_req};
  assign rdy  = {m1_rsp_ready, m0_rsp_ready};
  assign addr = {m1_addr, m0_addr};

  always_comb begin
    inflight = 2'b00;
    for (int i = 0; i < 2; i++)
      inflight[i] = infl_q.vld && (infl_q.own == req_id_e'(i[0]));
  end

  // A buffer popped this cycle frees its owner for a new issue.
  assign elig = req & ~inflight & (~rsp_vld_q | rdy);

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .elig_i (elig),
    .mode_i (PRIO_MODE),
    .gnt_o  (gnt_raw)
  );

  assign gnt      = rst_n ? gnt_raw : 2'b00;
  assign win      = gnt[1];
  assign win_addr = addr[win];
  assign misal    = CHECK_ALIGN && (win_addr[1:0] != 2'b00);

  // Misaligned grants still occupy the issue slot but never touch memory.
  assign mem_en   = (|gnt) & ~misal;
  assign mem_addr = (|gnt) ? win_addr : addr_q;
  assign infl_d   = '{vld: |gnt, own: req_id_e'(win), err: misal};

  always_comb begin
    rsp_vld_d  = rsp_vld_q;
    rsp_err_d  = rsp_err_q;
    rsp_data_d = rsp_data_q;
    for (int i = 0; i < 2; i++) begin
      if (infl_q.vld && (infl_q.own == req_id_e'(i[0]))) begin
        rsp_vld_d[i]  = 1'b1;
        rsp_err_d[i]  = infl_q.err;
        rsp_data_d[i] = infl_q.err ? '0 : mem_dout;
      end else if (rsp_vld_q[i] && rdy[i]) begin
        rsp_vld_d[i]  = 1'b0;
        rsp_err_d[i]  = 1'b0;
        rsp_data_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      infl_q     <= '{vld: 1'b0, own: REQ_FETCH, err: 1'b0};
      addr_q     <= '0;
      rsp_vld_q  <= '0;
      rsp_err_q  <= '0;
      rsp_data_q <= '0;
    end else begin
      infl_q     <= infl_d;
      addr_q     <= mem_addr;
      rsp_vld_q  <= rsp_vld_d;
      rsp_err_q  <= rsp_err_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign m0_gnt       = gnt[0];
  assign m1_gnt       = gnt[1];
  assign m0_rsp_valid = rsp_vld_q[0];
  assign m1_rsp_valid = rsp_vld_q[1];
  assign m0_rsp_err   = rsp_err_q[0];
  assign m1_rsp_err   = rsp_err_q[1];
  assign m0_rsp_data  = rsp_data_q[0];
  assign m1_rsp_data  = rsp_data_q[1];

endmodule

// File: tb/tb_bios_port_arbiter.sv
// Directed bench: round-robin instance checked by vector table and sequences,
// a fixed-priority instance checked for arbitration order.
module tb_bios_port_arbiter;

  localparam logic [31:0] WB = 32'hDEADBEEF;
  localparam logic [31:0] W0 = 32'h1000_0000;
  localparam logic [31:0] W1 = 32'h1000_0001;
  localparam logic [31:0] W2 = 32'h1000_0002;
  localparam logic [31:0] W3 = 32'h1000_0003;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m1_req, m0_rsp_ready, m1_rsp_ready;
  logic [11:0] m0_addr, m1_addr;

  logic        m0_gnt, m0_rsp_valid, m0_rsp_err, m1_gnt, m1_rsp_valid, m1_rsp_err, mem_en;
  logic [31:0] m0_rsp_data, m1_rsp_data, mem_dout;
  logic [11:0] mem_addr;

  logic        f_g0, f_v0, f_e0, f_g1, f_v1, f_e1, f_en;
  logic [31:0] f_d0, f_d1, f_mem_dout;
  logic [11:0] f_ma;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [11:0] a);
    return (a[11:2] == 10'd4) ? WB : (32'h1000_0000 | {22'b0, a[11:2]});
  endfunction

  always @(posedge clk) begin
    mem_dout   <= memf(mem_addr);
    f_mem_dout <= memf(f_ma);
  end

  bios_port_arbiter #(.PRIO_MODE(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt), .m0_rsp_valid(m0_rsp_valid),
    .m0_rsp_ready(m0_rsp_ready), .m0_rsp_data(m0_rsp_data), .m0_rsp_err(m0_rsp_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_gnt(m1_gnt), .m1_rsp_valid(m1_rsp_valid),
    .m1_rsp_ready(m1_rsp_ready), .m1_rsp_data(m1_rsp_data), .m1_rsp_err(m1_rsp_err),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_dout(mem_dout)
  );

  bios_port_arbiter #(.PRIO_MODE(1'b1)) dut_fx (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(f_g0), .m0_rsp_valid(f_v0),
    .m0_rsp_ready(m0_rsp_ready), .m0_rsp_data(f_d0), .m0_rsp_err(f_e0),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_gnt(f_g1), .m1_rsp_valid(f_v1),
    .m1_rsp_ready(m1_rsp_ready), .m1_rsp_data(f_d1), .m1_rsp_err(f_e1),
    .mem_en(f_en), .mem_addr(f_ma), .mem_dout(f_mem_dout)
  );

  typedef struct {
    logic r0; logic [11:0] a0; logic r1; logic [11:0] a1;
    logic g0; logic g1; logic en; logic [11:0] ma;
    logic v0; logic [31:0] d0; logic e0;
    logic v1; logic [31:0] d1; logic e1;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic r0, input logic [11:0] a0, input logic r1,
                              input logic [11:0] a1, input logic g0, input logic g1,
                              input logic en, input logic [11:0] ma,
                              input logic v0, input logic [31:0] d0, input logic e0,
                              input logic v1, input logic [31:0] d1, input logic e1);
    vec_t v;
    v.r0 = r0; v.a0 = a0; v.r1 = r1; v.a1 = a1;
    v.g0 = g0; v.g1 = g1; v.en = en; v.ma = ma;
    v.v0 = v0; v.d0 = d0; v.e0 = e0; v.v1 = v1; v.d1 = d1; v.e1 = e1;
    return v;
  endfunction

  function automatic logic [95:0] obs();
    return {13'b0, m0_gnt, m1_gnt, mem_en, mem_addr, m0_rsp_valid, m0_rsp_data, m0_rsp_err,
            m1_rsp_valid, m1_rsp_data, m1_rsp_err};
  endfunction

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic r0, input logic [11:0] a0, input logic y0,
                     input logic r1, input logic [11:0] a1, input logic y1);
    @(negedge clk);
    m0_req = r0; m0_addr = a0; m0_rsp_ready = y0;
    m1_req = r1; m1_addr = a1; m1_rsp_ready = y1;
    #1;
  endtask

  initial begin
    // Round-robin alternation from reset (pointer starts at requester 0).
    vq.push_back(mk(1, 12'h000, 1, 12'h004, 1, 0, 1, 12'h000, 0, 0,  0, 0, 0,  0));
    vq.push_back(mk(1, 12'h000, 1, 12'h004, 0, 1, 1, 12'h004, 0, 0,  0, 0, 0,  0));
    vq.push_back(mk(1, 12'h000, 1, 12'h004, 1, 0, 1, 12'h000, 1, W0, 0, 0, 0,  0));
    vq.push_back(mk(1, 12'h000, 1, 12'h004, 0, 1, 1, 12'h004, 0, 0,  0, 1, W1, 0));
    vq.push_back(mk(1, 12'h000, 1, 12'h004, 1, 0, 1, 12'h000, 1, W0, 0, 0, 0,  0));
    vq.push_back(mk(0, 12'h000, 0, 12'h004, 0, 0, 0, 12'h000, 0, 0,  0, 1, W1, 0));
    vq.push_back(mk(0, 12'h000, 0, 12'h004, 0, 0, 0, 12'h000, 1, W0, 0, 0, 0,  0));
    vq.push_back(mk(0, 12'h000, 0, 12'h004, 0, 0, 0, 12'h000, 0, 0,  0, 0, 0,  0));
    // Single m0 read of word 4, latency two cycles, address held when idle.
    vq.push_back(mk(1, 12'h010, 0, 12'h000, 1, 0, 1, 12'h010, 0, 0,  0, 0, 0,  0));
    vq.push_back(mk(0, 12'h010, 0, 12'h000, 0, 0, 0, 12'h010, 0, 0,  0, 0, 0,  0));
    vq.push_back(mk(0, 12'h010, 0, 12'h000, 0, 0, 0, 12'h010, 1, WB, 0, 0, 0,  0));
    vq.push_back(mk(0, 12'h010, 0, 12'h000, 0, 0, 0, 12'h010, 0, 0,  0, 0, 0,  0));
    // Misaligned m1 read: granted, no memory access, error response.
    vq.push_back(mk(0, 12'h000, 1, 12'h006, 0, 1, 0, 12'h006, 0, 0,  0, 0, 0,  0));
    vq.push_back(mk(0, 12'h000, 0, 12'h006, 0, 0, 0, 12'h006, 0, 0,  0, 0, 0,  0));
    vq.push_back(mk(0, 12'h000, 0, 12'h006, 0, 0, 0, 12'h006, 0, 0,  0, 1, 0,  1));
    vq.push_back(mk(0, 12'h000, 0, 12'h006, 0, 0, 0, 12'h006, 0, 0,  0, 0, 0,  0));
    // Pointer at m1 after an m0 grant: m1 wins the next contested cycle.
    vq.push_back(mk(1, 12'h008, 0, 12'h000, 1, 0, 1, 12'h008, 0, 0,  0, 0, 0,  0));
    vq.push_back(mk(0, 12'h008, 0, 12'h000, 0, 0, 0, 12'h008, 0, 0,  0, 0, 0,  0));
    vq.push_back(mk(1, 12'h008, 1, 12'h00C, 0, 1, 1, 12'h00C, 1, W2, 0, 0, 0,  0));
    vq.push_back(mk(1, 12'h008, 1, 12'h00C, 1, 0, 1, 12'h008, 0, 0,  0, 0, 0,  0));
    vq.push_back(mk(0, 12'h008, 0, 12'h00C, 0, 0, 0, 12'h008, 0, 0,  0, 1, W3, 0));
    vq.push_back(mk(0, 12'h008, 0, 12'h00C, 0, 0, 0, 12'h008, 1, W2, 0, 0, 0,  0));
    vq.push_back(mk(0, 12'h008, 0, 12'h00C, 0, 0, 0, 12'h008, 0, 0,  0, 0, 0,  0));

    // Reset state, with requests asserted to show gnt is held low.
    rst_n = 1'b0;
    m0_req = 1'b1; m0_addr = 12'h010; m0_rsp_ready = 1'b1;
    m1_req = 1'b1; m1_addr = 12'h006; m1_rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1 chk("reset_state", obs(), 96'h0);
    drv(0, 12'h000, 1, 0, 12'h000, 1);
    rst_n = 1'b1;

    for (int k = 0; k < vq.size(); k++) begin
      drv(vq[k].r0, vq[k].a0, 1'b1, vq[k].r1, vq[k].a1, 1'b1);
      chk($sformatf("vec[%0d]", k), obs(),
          {13'b0, vq[k].g0, vq[k].g1, vq[k].en, vq[k].ma, vq[k].v0, vq[k].d0, vq[k].e0,
           vq[k].v1, vq[k].d1, vq[k].e1});
    end

    // Backpressure: buffered response blocks a new m0 grant until popped.
    drv(1, 12'h010, 0, 0, 12'h000, 1);
    chk("bp_gnt", {95'b0, m0_gnt}, 96'h1);
    drv(1, 12'h010, 0, 0, 12'h000, 1);
    chk("bp_inflight", {95'b0, m0_gnt}, 96'h0);
    for (int c = 0; c < 5; c++) begin
      drv(1, 12'h010, 0, 0, 12'h000, 1);
      chk($sformatf("bp_stall[%0d]", c), {62'b0, m0_gnt, m0_rsp_valid, m0_rsp_data},
          {62'b0, 1'b0, 1'b1, WB});
    end
    drv(1, 12'h010, 1, 0, 12'h000, 1);
    chk("bp_release", {62'b0, m0_gnt, m0_rsp_valid, m0_rsp_data}, {62'b0, 1'b1, 1'b1, WB});
    drv(0, 12'h010, 1, 0, 12'h000, 1);
    chk("bp_pop", {94'b0, m0_gnt, m0_rsp_valid}, 96'h0);
    drv(0, 12'h010, 1, 0, 12'h000, 1);
    chk("bp_second", {63'b0, m0_rsp_valid, m0_rsp_data}, {63'b0, 1'b1, WB});
    drv(0, 12'h010, 1, 0, 12'h000, 1);

    // Reset while a read is in flight.
    drv(1, 12'h010, 1, 0, 12'h000, 1);
    chk("rst_pre_gnt", {95'b0, m0_gnt}, 96'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("rst_async", obs(), 96'h0);
    @(negedge clk);
    #1 chk("rst_hold", obs(), 96'h0);
    drv(0, 12'h010, 1, 0, 12'h000, 1);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drv(0, 12'h010, 1, 0, 12'h000, 1);
      chk($sformatf("rst_no_rsp[%0d]", c), {93'b0, m0_rsp_valid, m1_rsp_valid, mem_en}, 96'h0);
    end
    drv(1, 12'h000, 1, 1, 12'h004, 1);
    chk("rst_m0_pref", {81'b0, m0_gnt, m1_gnt, mem_en, mem_addr}, {81'b0, 3'b101, 12'h000});
    drv(0, 12'h000, 1, 0, 12'h004, 1);
    drv(0, 12'h000, 1, 0, 12'h004, 1);
    chk("rst_rsp", {63'b0, m0_rsp_valid, m0_rsp_data}, {63'b0, 1'b1, W0});
    drv(0, 12'h000, 1, 0, 12'h004, 1);

    // Fixed priority: m0 wins contested cycles even after its own grant.
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    drv(1, 12'h008, 1, 0, 12'h000, 1);
    chk("fx_solo", {93'b0, f_g0, f_g1, f_en}, 96'h5);
    drv(0, 12'h008, 1, 0, 12'h000, 1);
    chk("fx_idle", {94'b0, f_g0, f_g1}, 96'h0);
    drv(1, 12'h008, 1, 1, 12'h00C, 1);
    chk("fx_both_m0", {61'b0, f_g0, f_g1, f_v0, f_d0}, {61'b0, 2'b10, 1'b1, W2});
    for (int c = 0; c < 4; c++) begin
      drv(1, 12'h008, 1, 1, 12'h00C, 1);
      chk($sformatf("fx_alt[%0d]", c), {93'b0, f_g0, f_g1, f_en},
          {93'b0, (c % 2 == 1) ? 2'b10 : 2'b01, 1'b1});
      if (c == 2) chk("fx_m1_rsp", {63'b0, f_v1, f_d1}, {63'b0, 1'b1, W3});
    end
    repeat (3) drv(0, 12'h000, 1, 0, 12'h000, 1);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
